// File: rtl/sprite_arb_pkg.sv
// sprite_arb_pkg: shared constants and types for the spritesheet frameRAM read arbiter.
package sprite_arb_pkg;
   localparam int N_REQ_DEF   = 4;
   localparam int ADDR_W_DEF  = 17;
   localparam int DATA_W_DEF  = 4;
   localparam int RAM_LAT_DEF = 1;
   localparam int ID_W        = 4;
   typedef logic [1:0] beat_len_t;
   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
      logic            last;
   } tag_t;
endpackage

// File: rtl/sprite_rd_arbiter_rr_pick.sv
// rr_pick: combinational round-robin find-first, searching from last_id+1 with wrap.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_id,
   output logic [N-1:0]  oh,
   output logic [IW-1:0] idx,
   output logic          any_req
);
   always_comb begin
      int j;
      j       = 0;
      oh      = '0;
      idx     = '0;
      any_req = 1'b0;
      // walk farthest-first so the nearest requester overwrites
      for (int k = N; k >= 1; k--) begin
         j = (int'(last_id) + k) % N;
         if (req[j]) begin
            oh      = '0;
            oh[j]   = 1'b1;
            idx     = IW'(j);
            any_req = 1'b1;
         end
      end
   end
endmodule

// File: rtl/sprite_rd_arbiter.sv
// sprite_rd_arbiter: round-robin burst arbiter for the frameRAM read port with tagged returns.
// SPRITE_ARB_STATS_EN adds per-requester saturating beat counters readable via stat_sel.
module sprite_rd_arbiter
   import sprite_arb_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int RAM_LAT = RAM_LAT_DEF
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
`ifdef SPRITE_ARB_STATS_EN
   input  logic                      stat_clr,
   input  logic [$clog2(N_REQ)-1:0]  stat_sel,
   output logic [15:0]               stat_cnt,
`endif
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*2-1:0]        req_len,
   output logic [N_REQ-1:0]          gnt,
   output logic [ADDR_W-1:0]         ram_addr,
   output logic                      ram_rd_en,
   input  logic [DATA_W-1:0]         ram_rdata,
   output logic [N_REQ-1:0]          rvalid,
   output logic                      rlast,
   output logic [DATA_W-1:0]         rdata
);
   localparam int IW = $clog2(N_REQ);
   beat_len_t         beats_left;
   logic [IW-1:0]     last_id, cur_id, pick_idx;
   logic [N_REQ-1:0]  pick_oh;
   logic              any_req, idle;
   tag_t              pipe [RAM_LAT];
   tag_t              out_tag;

   rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
      .req     (req),
      .last_id (last_id),
      .oh      (pick_oh),
      .idx     (pick_idx),
      .any_req (any_req)
   );

   assign idle    = beats_left == '0;
   assign gnt     = (idle && Reset_n) ? pick_oh : '0;
   assign out_tag = pipe[RAM_LAT-1];
   assign rvalid  = out_tag.valid ? N_REQ'(1) << out_tag.id : '0;
   assign rlast   = out_tag.valid & out_tag.last;
   assign rdata   = ram_rdata;

   // the tag for the beat now on ram_addr enters the pipe alongside the RAM read
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         beats_left <= '0;
         last_id    <= IW'(N_REQ - 1);
         cur_id     <= '0;
         ram_addr   <= '0;
         ram_rd_en  <= 1'b0;
         for (int s = 0; s < RAM_LAT; s++) pipe[s] <= '0;
      end else begin
         pipe[0] <= '{valid: ram_rd_en, id: ID_W'(cur_id), last: idle};
         for (int s = 1; s < RAM_LAT; s++) pipe[s] <= pipe[s-1];
         if (!idle) begin
            ram_addr   <= ram_addr + 1'b1;
            ram_rd_en  <= 1'b1;
            beats_left <= beats_left - 1'b1;
         end else if (any_req) begin
            ram_addr   <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            ram_rd_en  <= 1'b1;
            cur_id     <= pick_idx;
            last_id    <= pick_idx;
            beats_left <= req_len[pick_idx*2 +: 2];
         end else begin
            ram_rd_en  <= 1'b0;
         end
      end
   end

`ifdef SPRITE_ARB_STATS_EN
   logic [15:0]   cnt [N_REQ];
   logic          issue;
   logic [IW-1:0] issue_id;
   assign issue    = !idle || any_req;
   assign issue_id = idle ? pick_idx : cur_id;
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
         stat_cnt <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++)
            if (stat_clr) cnt[i] <= '0;
            else if (issue && issue_id == IW'(i) && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 1'b1;
         stat_cnt <= cnt[stat_sel];
      end
   end
`endif
endmodule

// File: tb/tb_sprite_rd_arbiter.sv
// tb_sprite_rd_arbiter: directed and random checks of the arbiter against a beat-queue reference model.
module tb_sprite_rd_arbiter;
   localparam int N = 4, AW = 17, DW = 4;
   logic            Clk = 0, Reset_n = 0;
   logic [N-1:0]    req = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*2-1:0]  req_len = '0;
   logic [N-1:0]    gnt, rvalid;
   logic [AW-1:0]   ram_addr;
   logic            ram_rd_en, rlast;
   logic [DW-1:0]   ram_rdata = '0, rdata;

   typedef struct { bit v; int id; logic [AW-1:0] addr; bit last; } beat_t;
   beat_t sched[$];
   beat_t cur, prv, none;
   int last_g = N - 1;
   int errors = 0, checks = 0;

   sprite_rd_arbiter dut (
      .Clk(Clk), .Reset_n(Reset_n), .req(req), .req_addr(req_addr), .req_len(req_len),
      .gnt(gnt), .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_rdata(ram_rdata),
      .rvalid(rvalid), .rlast(rlast), .rdata(rdata)
   );

   always #10 Clk = ~Clk;

   function automatic logic [DW-1:0] ram_f(input logic [AW-1:0] a);
      return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[16:13] ^ {3'b0, a[12]};
   endfunction

   always @(posedge Clk) ram_rdata <= ram_f(ram_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int winner();
      if (sched.size() != 0) return -1;
      for (int k = 1; k <= N; k++)
         if (req[(last_g + k) % N]) return (last_g + k) % N;
      return -1;
   endfunction

   task automatic set_req(input int i, input logic [AW-1:0] a, input int len);
      req[i] = 1'b1;
      req_addr[i*AW +: AW] = a;
      req_len[i*2 +: 2] = 2'(len);
   endtask

   // one clock of model vs DUT; inputs must already be driven
   task automatic cycle(input bit hold);
      int w, len;
      logic [N-1:0] eg;
      logic [AW-1:0] a;
      beat_t b;
      w = winner();
      eg = (w >= 0) ? N'(1) << w : '0;
      @(negedge Clk);
      chk("gnt", 32'(gnt), 32'(eg));
      chk("rd_en", 32'(ram_rd_en), 32'(cur.v));
      if (cur.v) chk("ram_addr", 32'(ram_addr), 32'(cur.addr));
      chk("rvalid", 32'(rvalid), prv.v ? 32'(1) << prv.id : 32'd0);
      chk("rlast", 32'(rlast), 32'(prv.v && prv.last));
      if (prv.v) chk("rdata", 32'(rdata), 32'(ram_f(prv.addr)));
      if (w >= 0) begin
         len = int'(req_len[w*2 +: 2]);
         a = req_addr[w*AW +: AW];
         for (int k = 0; k <= len; k++) begin
            b.v = 1; b.id = w; b.addr = a + AW'(k); b.last = (k == len);
            sched.push_back(b);
         end
         last_g = w;
      end
      @(posedge Clk);
      prv = cur;
      cur = (sched.size() != 0) ? sched.pop_front() : none;
      #1;
      if (!hold) req = req & ~eg;
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      @(negedge Clk);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_addr", 32'(ram_addr), 0);
      chk("rst_rd_en", 32'(ram_rd_en), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_rlast", 32'(rlast), 0);
      sched.delete();
      cur = none; prv = none; last_g = N - 1;
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
   endtask

   initial begin
      none = '{0, 0, '0, 0};
      cur = none; prv = none;
      @(posedge Clk);
      #1;
      do_reset();
      set_req(0, 17'h00100, 0);
      repeat (4) cycle(0);
      set_req(2, 17'h1FFFE, 3);
      repeat (7) cycle(0);
      for (int i = 0; i < N; i++) set_req(i, AW'(17'h01000 + i * 16), 0);
      repeat (6) cycle(1);
      req = '0;
      repeat (3) cycle(0);
      set_req(1, 17'h0A000, 3);
      cycle(0);
      set_req(0, 17'h00050, 1);
      repeat (8) cycle(0);
      set_req(1, 17'h02000, 3);
      cycle(0);
      cycle(0);
      set_req(0, 17'h00300, 0);
      set_req(3, 17'h00400, 1);
      do_reset();
      repeat (6) cycle(0);
      repeat (400) begin
         for (int i = 0; i < N; i++) begin
            if (!req[i] && $urandom_range(0, 3) == 0) set_req(i, AW'($urandom), $urandom_range(0, 3));
            else if (req[i] && $urandom_range(0, 15) == 0) req[i] = 1'b0;
         end
         cycle(0);
      end
      req = '0;
      repeat (8) cycle(0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sprite_rd_arbiter.md
# sprite_rd_arbiter

Shares the single read port of the spritesheet frameRAM among several sprite fetchers: Pac-Man, the ghosts, and the maze/pellet layer. The block grants one requester at a time using round-robin order. It issues either a single read or a short burst of consecutive addresses, and returns the data tagged to the requester that owns it. It sits between the per-sprite fetch engines and frameRAM's read_address/data_Out, in the Clk (50 MHz) domain.

## Interface
Parameters:
- N_REQ, 4: number of requesters.
- ADDR_W, 17: frameRAM address width.
- DATA_W, 4: frameRAM word width (palette index).
- RAM_LAT, 1: frameRAM read latency in cycles (1..3).

Ports:
- Clk  in  1  single clock for the whole block.
- Reset_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester read request. Held until granted.
- req_addr  in  N_REQ*ADDR_W  start address. Requester i uses slice [i*ADDR_W +: ADDR_W].
- req_len  in  N_REQ*2  number of beats minus 1 (0..3). Requester i uses slice [i*2 +: 2].
- gnt  out  N_REQ  one-hot, single-cycle, combinational acceptance.
- ram_addr  out  ADDR_W  registered frameRAM read address.
- ram_rd_en  out  1  registered; high when ram_addr is a valid beat.
- ram_rdata  in  DATA_W  frameRAM data_Out.
- rvalid  out  N_REQ  one-hot; returned data belongs to requester i.
- rlast  out  1  high with the final beat of a burst.
- rdata  out  DATA_W  equals ram_rdata. Meaningful only while rvalid is nonzero.

## Operation
- Two states, derived from the 2-bit register beats_left:
  - IDLE: beats_left == 0.
  - BURST: beats_left != 0.
- Arbitration happens only in IDLE.
  - Search order starts at last_id+1 and wraps modulo N_REQ.
  - The first i with req[i] set receives gnt[i]=1 for that cycle.
- On the acceptance edge:
  - ram_addr <= req_addr[i]; ram_rd_en <= 1; cur_id <= i; last_id <= i.
  - beats_left <= req_len[i].
  - The tag pipeline is loaded with {i, last = (req_len[i]==0)}.
- Edge while in BURST:
  - ram_addr <= ram_addr+1. Wraps modulo 2^ADDR_W with no error.
  - ram_rd_en <= 1; beats_left <= beats_left-1.
  - Tag is {cur_id, last = (beats_left==1)}.
- Edge while in IDLE with no request: ram_rd_en <= 0, and the tag pipeline is loaded with an invalid entry.
- Tag pipeline: RAM_LAT stages of {valid, id, last}.
  - The output stage drives rvalid (one-hot of id when valid) and rlast.
- gnt is never asserted in BURST. Requests that arrive during a burst wait for it to finish.
- A requester that drops req before gnt is simply not served.
- When gnt and a new req from the same requester occur in the same cycle, gnt counts as acceptance of the held request. The requester must present the next request from the following cycle.
- Reset values:
  - gnt = 0, ram_addr = 0, ram_rd_en = 0, rvalid = 0, rlast = 0.
  - beats_left = 0, last_id = N_REQ-1, so requester 0 wins the first arbitration.
  - Tag pipeline all invalid.
- Reset asserted mid-burst aborts the burst. In-flight beats return no rvalid.

## Timing
- gnt in cycle t (combinational from req and state).
- First ram_addr and ram_rd_en at t+1.
- First rvalid/rdata at t+1+RAM_LAT.
- Beats are contiguous: a burst of L beats occupies ram_rd_en for cycles t+1..t+L.
- Next grant is possible in cycle t+L, so there are zero bubbles between bursts.
- Sustained throughput is one beat per cycle.
- Worst-case wait for a requester: (N_REQ-1)*4 beat cycles.

## Configuration
- SPRITE_ARB_STATS_EN defined:
  - Adds ports stat_clr (in, 1), stat_sel (in, clog2(N_REQ)) and stat_cnt (out, 16).
  - Each requester has a 16-bit beat counter. It increments once per issued beat and saturates at 0xFFFF.
  - stat_clr synchronously zeros all counters and takes priority over a same-cycle increment.
  - stat_cnt is a registered read of counter[stat_sel], valid one cycle after stat_sel.
  - Reset zeros all counters.
- SPRITE_ARB_STATS_EN undefined: these ports and counters do not exist, and arbitration behaviour is identical.

## Structure
- Package sprite_arb_pkg holds:
  - Default constants for N_REQ, ADDR_W, DATA_W, RAM_LAT.
  - Typedef beat_len_t (2 bits).
  - Typedef tag_t, a struct of valid, id and last.
- Sub-module rr_pick: combinational round-robin find-first.
  - Inputs: req and last_id.
  - Outputs: one-hot and index plus any_req.
  - Instantiated once.

## Test plan
- Single read: req[0], addr 0x00100, len 0 → gnt[0] in cycle 0; ram_addr=0x00100 in cycle 1; rvalid=0001 and rlast=1 in cycle 2 (RAM_LAT=1).
- Burst of 4: req[2], addr 0x1FFFE, len 3 → ram_addr sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001. rvalid=0100 for 4 cycles, rlast on the 4th only.
- Round robin: all four requesters held with len 0 → grants in order 0, 1, 2, 3, 0, with one grant per cycle and no idle cycles.
- Contention during burst: req[1] len 3 granted, then req[0] raised → gnt[0] appears in the cycle of the last beat issue, and ram_rd_en stays continuously high.
- Reset mid-burst: Reset_n low during beat 2 of 4 → all outputs zero. After release, no rvalid from the aborted burst, and requester 0 wins first.
- With SPRITE_ARB_STATS_EN: 3 bursts of len 3 from requester 1 → stat_cnt=12 for stat_sel=1. stat_clr → 0.
